// File: rtl/noaa_sample_feeder.sv
// noaa_sample_feeder: sample FIFO plus held-result register for NOAA_module.
// Upstream words are buffered in a circular FIFO and presented on TN/MODE in
// response to SAMPLE. AVG_SD is captured on DONE into a valid/ack register.
// Build option: define NOAA_FEEDER_STATS_EN to include the window counter
// (RES_COUNT) and the sticky UNDERRUN/OVERRUN flags; otherwise they read 0.
module noaa_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int TN_W  = 12
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [TN_W-1:0] IN_TN,
  input  logic            IN_MODE,
  input  logic            SAMPLE,
  output logic [TN_W-1:0] TN,
  output logic            MODE,
  output logic            HEAD_VALID,
  input  logic            DONE,
  input  logic [TN_W-1:0] AVG_SD,
  output logic            RES_VALID,
  input  logic            RES_ACK,
  output logic [TN_W-1:0] RES_DATA,
  output logic            RES_MODE,
  output logic [7:0]      RES_COUNT,
  output logic            UNDERRUN,
  output logic            OVERRUN
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic            mode;
    logic [TN_W-1:0] tn;
  } entry_t;

  typedef enum logic {S_EMPTY, S_HELD} res_state_e;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q, rptr_nx;
  logic            full, empty, push, pop, nxt_avail;
  entry_t          head_q, head_d;
  logic            head_vld_q, head_vld_d;
  res_state_e      state_q, state_d;
  logic            capture;
  logic [TN_W-1:0] res_data_q;
  logic            res_mode_q, last_mode_q;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign IN_READY  = !RESET && !full;
  assign push      = IN_VALID && IN_READY;
  assign pop       = SAMPLE && head_vld_q;
  assign rptr_nx   = rptr_q + PW'(1);
  // The entry behind the head must already be stored; a same-edge push is not bypassed.
  assign nxt_avail = (rptr_nx != wptr_q);

  assign TN         = head_q.tn;
  assign MODE       = head_q.mode;
  assign HEAD_VALID = head_vld_q;
  assign RES_VALID  = (state_q == S_HELD);
  assign RES_DATA   = res_data_q;
  assign RES_MODE   = res_mode_q;

  // FIFO storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {IN_MODE, IN_TN};
  end

  // Head register: advance on pop, or fetch the head once the FIFO goes non-empty.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (pop) begin
      if (nxt_avail) begin
        head_d     = mem_q[rptr_nx[AW-1:0]];
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (!head_vld_q && !empty) begin
      head_d     = mem_q[rptr_q[AW-1:0]];
      head_vld_d = 1'b1;
    end
  end

  // Pointers and head presentation registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_nx;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  // Result FSM next state: DONE always captures; a lone ack releases the result.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_EMPTY: if (DONE) begin
        capture = 1'b1;
        state_d = S_HELD;
      end
      S_HELD: if (DONE) begin
        capture = 1'b1;
      end else if (RES_ACK) begin
        state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Result FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // Result data; RES_MODE is the mode of the most recent consumed word, same-edge pop included.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      res_data_q  <= '0;
      res_mode_q  <= 1'b0;
      last_mode_q <= 1'b0;
    end else begin
      if (pop) last_mode_q <= head_q.mode;
      if (capture) begin
        res_data_q <= AVG_SD;
        res_mode_q <= pop ? head_q.mode : last_mode_q;
      end
    end
  end

`ifdef NOAA_FEEDER_STATS_EN
  logic [7:0] cnt_q, cnt_inc, res_count_q;
  logic       underrun_q, overrun_q;

  // A pop in the DONE cycle belongs to the closing window.
  assign cnt_inc   = (pop && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  assign RES_COUNT = res_count_q;
  assign UNDERRUN  = underrun_q;
  assign OVERRUN   = overrun_q;

  // Window counter and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      res_count_q <= '0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (DONE) begin
        res_count_q <= cnt_inc;
        cnt_q       <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
      if (SAMPLE && !head_vld_q) underrun_q <= 1'b1;
      if (DONE && RES_VALID && !RES_ACK) overrun_q <= 1'b1;
    end
  end
`else
  assign RES_COUNT = '0;
  assign UNDERRUN  = 1'b0;
  assign OVERRUN   = 1'b0;
`endif

endmodule

// File: tb/tb_noaa_sample_feeder.sv
// Self-checking bench for noaa_sample_feeder: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_noaa_sample_feeder;
  localparam int DEPTH = 8;
  localparam int TN_W  = 12;
`ifdef NOAA_FEEDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            CLK = 1'b0, RESET = 1'b1, IN_VALID = 1'b0, IN_MODE = 1'b0;
  logic            SAMPLE = 1'b0, DONE = 1'b0, RES_ACK = 1'b0;
  logic [TN_W-1:0] IN_TN = '0, AVG_SD = '0;
  logic            IN_READY, MODE, HEAD_VALID, RES_VALID, RES_MODE, UNDERRUN, OVERRUN;
  logic [TN_W-1:0] TN, RES_DATA;
  logic [7:0]      RES_COUNT;

  noaa_sample_feeder #(.DEPTH(DEPTH), .TN_W(TN_W)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_TN(IN_TN), .IN_MODE(IN_MODE), .SAMPLE(SAMPLE), .TN(TN), .MODE(MODE),
    .HEAD_VALID(HEAD_VALID), .DONE(DONE), .AVG_SD(AVG_SD), .RES_VALID(RES_VALID),
    .RES_ACK(RES_ACK), .RES_DATA(RES_DATA), .RES_MODE(RES_MODE),
    .RES_COUNT(RES_COUNT), .UNDERRUN(UNDERRUN), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: queue of stored words {mode, tn} (head word included).
  logic [TN_W:0]   mq [$];
  bit              m_rst, m_hv, m_mode, m_held, m_rmode, m_last, m_und, m_ovr;
  logic [TN_W-1:0] m_tn, m_rdata;
  int              m_cnt, m_rcount;

  // Drive one cycle of inputs, advance the model across the edge, sample #1 after it.
  task automatic step(input bit r, input bit iv, input logic [TN_W-1:0] itn, input bit im,
                      input bit smp, input bit dn, input logic [TN_W-1:0] avg, input bit ack);
    bit psh, pp;
    RESET = r; IN_VALID = iv; IN_TN = itn; IN_MODE = im;
    SAMPLE = smp; DONE = dn; AVG_SD = avg; RES_ACK = ack;
    m_rst = r;
    if (r) begin
      mq.delete();
      m_hv = 0; m_tn = '0; m_mode = 0; m_held = 0; m_rdata = '0; m_rmode = 0;
      m_last = 0; m_cnt = 0; m_rcount = 0; m_und = 0; m_ovr = 0;
    end else begin
      psh = iv && (mq.size() < DEPTH);
      pp  = smp && m_hv;
      if (smp && !m_hv) m_und = 1;
      if (pp) begin
        m_last = mq[0][TN_W];
        void'(mq.pop_front());
        if (mq.size() > 0) begin
          m_tn = mq[0][TN_W-1:0]; m_mode = mq[0][TN_W]; m_hv = 1;
        end else begin
          m_hv = 0;
        end
      end else if (!m_hv && mq.size() > 0) begin
        m_tn = mq[0][TN_W-1:0]; m_mode = mq[0][TN_W]; m_hv = 1;
      end
      if (dn) begin
        m_rcount = (pp && m_cnt < 255) ? m_cnt + 1 : m_cnt;
        m_cnt = 0;
      end else if (pp && m_cnt < 255) begin
        m_cnt++;
      end
      if (dn) begin
        if (m_held && !ack) m_ovr = 1;
        m_held = 1; m_rdata = avg; m_rmode = m_last;
      end else if (m_held && ack) begin
        m_held = 0;
      end
      if (psh) mq.push_back({im, itn});
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 12'd55, 1, 1, 1, 12'd9, 0);
    step(1, 1, 12'd56, 1, 1, 1, 12'd9, 1);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", IN_READY); end
    checks++; if (HEAD_VALID !== 1'b0) begin errors++; $display("FAIL reset_head_valid: got %b exp 0", HEAD_VALID); end
    checks++; if (TN !== 12'd0 || MODE !== 1'b0) begin errors++; $display("FAIL reset_tn_mode: got %0d/%b exp 0/0", TN, MODE); end
    checks++; if (RES_VALID !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b exp 0", RES_VALID); end
    checks++; if (RES_DATA !== 12'd0 || RES_MODE !== 1'b0) begin errors++; $display("FAIL reset_res_data: got %0d/%b exp 0/0", RES_DATA, RES_MODE); end
    checks++; if (RES_COUNT !== 8'd0 || UNDERRUN !== 1'b0 || OVERRUN !== 1'b0) begin
      errors++; $display("FAIL reset_stats: got %0d/%b/%b exp 0/0/0", RES_COUNT, UNDERRUN, OVERRUN);
    end
  endtask

  task automatic test_fill_drain();
    logic [TN_W-1:0] ex [3];
    ex[0] = 12'd100; ex[1] = 12'd200; ex[2] = 12'd300;
    step(0, 1, 12'd100, 0, 0, 0, '0, 0);
    checks++; if (HEAD_VALID !== 1'b0) begin errors++; $display("FAIL fill_latency: got %b exp 0", HEAD_VALID); end
    step(0, 1, 12'd200, 0, 0, 0, '0, 0);
    checks++; if (HEAD_VALID !== 1'b1 || TN !== 12'd100) begin
      errors++; $display("FAIL fill_first_head: got %b/%0d exp 1/100", HEAD_VALID, TN);
    end
    step(0, 1, 12'd300, 0, 0, 0, '0, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (HEAD_VALID !== 1'b1 || TN !== ex[i]) begin
        errors++; $display("FAIL drain_seq%0d: got %b/%0d exp 1/%0d", i, HEAD_VALID, TN, ex[i]);
      end
      step(0, 0, '0, 0, 1, 0, '0, 0);
    end
    checks++; if (HEAD_VALID !== 1'b0 || TN !== 12'd300) begin
      errors++; $display("FAIL drain_empty_hold: got %b/%0d exp 0/300", HEAD_VALID, TN);
    end
  endtask

  task automatic test_full_wrap();
    logic [TN_W-1:0] w [9];
    bit              wm [9];
    for (int i = 0; i < 9; i++) begin
      w[i] = 12'(1000 + 7 * i); wm[i] = i[0];
    end
    for (int i = 0; i < 8; i++) step(0, 1, w[i], wm[i], 0, 0, '0, 0);
    checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", IN_READY); end
    step(0, 1, w[8], wm[8], 0, 0, '0, 0);
    checks++; if (IN_READY !== 1'b0 || HEAD_VALID !== 1'b1 || TN !== w[0]) begin
      errors++; $display("FAIL full_reject: got %b/%b/%0d exp 0/1/%0d", IN_READY, HEAD_VALID, TN, w[0]);
    end
    step(0, 1, w[8], wm[8], 1, 0, '0, 0);
    checks++; if (IN_READY !== 1'b1 || TN !== w[1]) begin
      errors++; $display("FAIL full_after_pop: got %b/%0d exp 1/%0d", IN_READY, TN, w[1]);
    end
    step(0, 1, w[8], wm[8], 0, 0, '0, 0);
    for (int i = 1; i < 9; i++) begin
      checks++; if (HEAD_VALID !== 1'b1 || TN !== w[i] || MODE !== wm[i]) begin
        errors++; $display("FAIL wrap_order%0d: got %b/%0d/%b exp 1/%0d/%b", i, HEAD_VALID, TN, MODE, w[i], wm[i]);
      end
      step(0, 0, '0, 0, 1, 0, '0, 0);
    end
    checks++; if (HEAD_VALID !== 1'b0 || TN !== w[8]) begin
      errors++; $display("FAIL wrap_empty: got %b/%0d exp 0/%0d", HEAD_VALID, TN, w[8]);
    end
  endtask

  task automatic test_underrun();
    logic [TN_W-1:0] held;
    held = TN;
    step(0, 0, '0, 0, 1, 0, '0, 0);
    checks++; if (UNDERRUN !== STATS) begin errors++; $display("FAIL underrun_flag: got %b exp %b", UNDERRUN, STATS); end
    checks++; if (TN !== held || HEAD_VALID !== 1'b0) begin
      errors++; $display("FAIL underrun_hold: got %0d/%b exp %0d/0", TN, HEAD_VALID, held);
    end
    step(0, 1, 12'd77, 1, 0, 0, '0, 0);
    idle();
    checks++; if (HEAD_VALID !== 1'b1 || TN !== 12'd77 || MODE !== 1'b1) begin
      errors++; $display("FAIL underrun_no_pop: got %b/%0d/%b exp 1/77/1", HEAD_VALID, TN, MODE);
    end
    step(0, 0, '0, 0, 1, 0, '0, 0);
  endtask

  task automatic test_result();
    step(1, 0, '0, 0, 0, 0, '0, 0);
    step(0, 1, 12'd11, 0, 0, 0, '0, 0);
    step(0, 1, 12'd22, 0, 0, 0, '0, 0);
    step(0, 1, 12'd33, 0, 0, 0, '0, 0);
    step(0, 1, 12'd44, 1, 0, 0, '0, 0);
    idle();
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1, 0, '0, 0);
    step(0, 0, '0, 0, 0, 1, 12'd250, 0);
    checks++; if (RES_VALID !== 1'b1 || RES_DATA !== 12'd250 || RES_MODE !== 1'b1) begin
      errors++; $display("FAIL result_capture: got %b/%0d/%b exp 1/250/1", RES_VALID, RES_DATA, RES_MODE);
    end
    checks++; if (RES_COUNT !== (STATS ? 8'd4 : 8'd0) || OVERRUN !== 1'b0) begin
      errors++; $display("FAIL result_count: got %0d/%b exp %0d/0", RES_COUNT, OVERRUN, STATS ? 4 : 0);
    end
    step(0, 0, '0, 0, 0, 1, 12'd260, 0);
    checks++; if (RES_VALID !== 1'b1 || RES_DATA !== 12'd260 || OVERRUN !== STATS) begin
      errors++; $display("FAIL result_overrun: got %b/%0d/%b exp 1/260/%b", RES_VALID, RES_DATA, OVERRUN, STATS);
    end
  endtask

  task automatic test_ack_done();
    step(1, 0, '0, 0, 0, 0, '0, 0);
    step(0, 0, '0, 0, 0, 1, 12'd240, 0);
    step(0, 0, '0, 0, 0, 1, 12'd270, 1);
    checks++; if (RES_VALID !== 1'b1 || RES_DATA !== 12'd270 || OVERRUN !== 1'b0) begin
      errors++; $display("FAIL ack_done: got %b/%0d/%b exp 1/270/0", RES_VALID, RES_DATA, OVERRUN);
    end
    step(0, 0, '0, 0, 0, 0, '0, 1);
    checks++; if (RES_VALID !== 1'b0 || RES_DATA !== 12'd270) begin
      errors++; $display("FAIL ack_release: got %b/%0d exp 0/270", RES_VALID, RES_DATA);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 12'd5, 0, 0, 0, '0, 0);
    step(0, 1, 12'd6, 0, 0, 0, '0, 0);
    step(0, 1, 12'd7, 0, 0, 1, 12'd123, 0);
    checks++; if (HEAD_VALID !== 1'b1 || RES_VALID !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got %b/%b exp 1/1", HEAD_VALID, RES_VALID);
    end
    step(1, 0, '0, 0, 0, 0, '0, 0);
    checks++; if (HEAD_VALID !== 1'b0 || RES_VALID !== 1'b0 || RES_DATA !== 12'd0) begin
      errors++; $display("FAIL mid_reset: got %b/%b/%0d exp 0/0/0", HEAD_VALID, RES_VALID, RES_DATA);
    end
    idle();
    idle();
    checks++; if (HEAD_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++; $display("FAIL mid_discard: got %b/%b exp 0/1", HEAD_VALID, IN_READY);
    end
  endtask

  task automatic test_random();
    bit              r, iv, im, smp, dn, ack;
    logic [TN_W-1:0] itn, avg;
    int              nerr;
    step(1, 0, '0, 0, 0, 0, '0, 0);
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      itn = 12'($urandom);
      im  = 1'($urandom);
      smp = ($urandom_range(0, 2) != 0);
      dn  = ($urandom_range(0, 9) == 0);
      avg = 12'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      step(r, iv, itn, im, smp, dn, avg, ack);
      nerr = errors;
      checks++; if (IN_READY !== (!m_rst && mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %b", n, IN_READY); end
      checks++; if (HEAD_VALID !== m_hv || TN !== m_tn || MODE !== m_mode) begin
        errors++; $display("FAIL rnd_head@%0d: got %b/%0d/%b exp %b/%0d/%b", n, HEAD_VALID, TN, MODE, m_hv, m_tn, m_mode);
      end
      checks++; if (RES_VALID !== m_held || RES_DATA !== m_rdata || RES_MODE !== m_rmode) begin
        errors++; $display("FAIL rnd_result@%0d: got %b/%0d/%b exp %b/%0d/%b", n, RES_VALID, RES_DATA, RES_MODE, m_held, m_rdata, m_rmode);
      end
      checks++; if (RES_COUNT !== (STATS ? 8'(m_rcount) : 8'd0) || UNDERRUN !== (STATS && m_und) || OVERRUN !== (STATS && m_ovr)) begin
        errors++; $display("FAIL rnd_stats@%0d: got %0d/%b/%b exp %0d/%b/%b", n, RES_COUNT, UNDERRUN, OVERRUN,
                           STATS ? m_rcount : 0, STATS && m_und, STATS && m_ovr);
      end
      if (errors - nerr > 0 && errors > 20) break;
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_wrap();
    test_underrun();
    test_result();
    test_ack_done();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
